// File: rtl/tmds_pkg.sv
// Shared types and code tables for the multi-channel TMDS/TERC4 encoder.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned AUX_W  = 4;
  localparam int unsigned CTL_W  = 2;
  localparam int unsigned DISP_W = 5;
  localparam int DISP_BOUND = 10;

  typedef enum logic [1:0] {
    TMDS_CTL   = 2'd0,
    TMDS_VID   = 2'd1,
    TMDS_TERC4 = 2'd2,
    TMDS_GB    = 2'd3
  } tmds_mode_e;

  localparam logic [SYM_W-1:0] CTL_CODE_0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTL_CODE_1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTL_CODE_2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTL_CODE_3 = 10'b1010101011;

  localparam logic [SYM_W-1:0] TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [SYM_W-1:0] ctl_code(input logic [CTL_W-1:0] c);
    logic [SYM_W-1:0] s;
    case (c)
      2'd0:    s = CTL_CODE_0;
      2'd1:    s = CTL_CODE_1;
      2'd2:    s = CTL_CODE_2;
      default: s = CTL_CODE_3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 transition-minimising, stage 2 mode decode and DC balance.
// With TMDS_DISP_MON_EN defined the running disparity is exported on disp.
module tmds_lane_enc
  import tmds_pkg::*;
#(
  parameter int unsigned LANE_IDX     = 0,
  parameter logic [9:0]  GB_ODD_CODE  = 10'b0100110011,
  parameter logic [9:0]  GB_EVEN_CODE = 10'b1011001100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  tmds_mode_e        mode,
  input  logic [CTL_W-1:0]  ctl,
  input  logic [BYTE_W-1:0] data,
  input  logic [AUX_W-1:0]  aux,
  output logic [SYM_W-1:0]  sym_q
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [DISP_W-1:0] disp
`endif
);

  localparam logic [SYM_W-1:0] GB_CODE = (LANE_IDX % 2 == 0) ? GB_EVEN_CODE : GB_ODD_CODE;

  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1_d, n1_q, n0_d, n0_q, n1_data;
  logic              use_xnor;
  tmds_mode_e        mode_q;
  logic [CTL_W-1:0]  ctl_q;
  logic [AUX_W-1:0]  aux_q;
  logic [SYM_W-1:0]  sym_d;
  logic [DISP_W-1:0] cnt_d, cnt_q, n1s, n0s;

  // Stage 1: XOR/XNOR chain and ones count of the chained byte
  always_comb begin
    n1_data = '0;
    for (int i = 0; i < 8; i++) n1_data = n1_data + 4'(data[i]);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    qm_d = '0;
    qm_d[0] = data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    qm_d[8] = ~use_xnor;
    n1_d = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + 4'(qm_d[i]);
    n0_d = 4'd8 - n1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q   <= '0;
      n1_q   <= '0;
      n0_q   <= '0;
      mode_q <= TMDS_CTL;
      ctl_q  <= '0;
      aux_q  <= '0;
    end else if (ce) begin
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      n0_q   <= n0_d;
      mode_q <= mode;
      ctl_q  <= ctl;
      aux_q  <= aux;
    end
  end

  // Stage 2: symbol select; non-video modes restart the disparity at zero
  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    n1s   = {1'b0, n1_q};
    n0s   = {1'b0, n0_q};
    if (ce) begin
      case (mode_q)
        TMDS_CTL: begin
          sym_d = ctl_code(ctl_q);
          cnt_d = '0;
        end
        TMDS_TERC4: begin
          sym_d = TERC4_LUT[aux_q];
          cnt_d = '0;
        end
        TMDS_GB: begin
          sym_d = GB_CODE;
          cnt_d = '0;
        end
        TMDS_VID: begin
          if ((cnt_q == '0) || (n1_q == n0_q)) begin
            if (qm_q[8]) begin
              sym_d = {2'b01, qm_q[7:0]};
              cnt_d = cnt_q + n1s - n0s;
            end else begin
              sym_d = {2'b10, ~qm_q[7:0]};
              cnt_d = cnt_q + n0s - n1s;
            end
          end else if ((!cnt_q[4] && (n1_q > n0_q)) || (cnt_q[4] && (n1_q < n0_q))) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + {3'b000, qm_q[8], 1'b0} + n0s - n1s;
          end else begin
            sym_d = {1'b0, qm_q};
            cnt_d = cnt_q + n1s - n0s - {3'b000, ~qm_q[8], 1'b0};
          end
        end
        default: begin
          sym_d = sym_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q <= CTL_CODE_0;
      cnt_q <= '0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef TMDS_DISP_MON_EN
  assign disp = cnt_q;
`endif

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS/TERC4 encoder, CHANNELS lanes in lock-step, 2 enabled cycles latency.
// Optional TMDS_DISP_MON_EN adds oDISP/oDISP_ERR disparity monitoring.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNELS     = 3,
  parameter logic [9:0]  GB_ODD_CODE  = 10'b0100110011,
  parameter logic [9:0]  GB_EVEN_CODE = 10'b1011001100
) (
  input  logic                         iCLK,
  input  logic                         iRESETn,
  input  logic                         iCE,
  input  logic [1:0]                   iMODE,
  input  logic [CTL_W*CHANNELS-1:0]    iCTL,
  input  logic [BYTE_W*CHANNELS-1:0]   iDATA,
  input  logic [AUX_W*CHANNELS-1:0]    iAUX,
  output logic [SYM_W*CHANNELS-1:0]    oDATA,
  output logic                         oVALID
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [DISP_W*CHANNELS-1:0]   oDISP,
  output logic                         oDISP_ERR
`endif
);

  logic v1_d, v1_q, valid_d, valid_q;

  // Valid follows the two-stage pipeline fill after reset
  always_comb begin
    v1_d    = v1_q;
    valid_d = valid_q;
    if (iCE) begin
      v1_d    = 1'b1;
      valid_d = v1_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      valid_q <= valid_d;
    end
  end

  assign oVALID = valid_q;

`ifdef TMDS_DISP_MON_EN
  logic [DISP_W-1:0] disp_w [CHANNELS];
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    tmds_lane_enc #(
      .LANE_IDX     (g),
      .GB_ODD_CODE  (GB_ODD_CODE),
      .GB_EVEN_CODE (GB_EVEN_CODE)
    ) u_lane (
      .clk   (iCLK),
      .rst_n (iRESETn),
      .ce    (iCE),
      .mode  (tmds_mode_e'(iMODE)),
      .ctl   (iCTL[CTL_W*g +: CTL_W]),
      .data  (iDATA[BYTE_W*g +: BYTE_W]),
      .aux   (iAUX[AUX_W*g +: AUX_W]),
      .sym_q (oDATA[SYM_W*g +: SYM_W])
`ifdef TMDS_DISP_MON_EN
      ,
      .disp  (disp_w[g])
`endif
    );
`ifdef TMDS_DISP_MON_EN
    assign oDISP[DISP_W*g +: DISP_W] = disp_w[g];
`endif
  end

`ifdef TMDS_DISP_MON_EN
  localparam logic signed [DISP_W-1:0] DISP_MAX = DISP_W'(DISP_BOUND);

  logic err_d, err_q;

  // Sticky out-of-bound flag across all lanes
  always_comb begin
    err_d = err_q;
    for (int n = 0; n < int'(CHANNELS); n++)
      if (($signed(disp_w[n]) > DISP_MAX) || ($signed(disp_w[n]) < -DISP_MAX)) err_d = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign oDISP_ERR = err_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Self-checking bench for tmds_encoder_mc: directed vector table plus randomized model compare.
module tb_tmds_encoder_mc;

  localparam int CH = 3;

  logic              iCLK = 1'b0;
  logic              iRESETn, iCE;
  logic [1:0]        iMODE;
  logic [2*CH-1:0]   iCTL;
  logic [8*CH-1:0]   iDATA;
  logic [4*CH-1:0]   iAUX;
  logic [10*CH-1:0]  oDATA;
  logic              oVALID;
`ifdef TMDS_DISP_MON_EN
  logic [5*CH-1:0]   oDISP;
  logic              oDISP_ERR;
`endif

  tmds_encoder_mc #(.CHANNELS(CH)) dut (
    .iCLK    (iCLK),
    .iRESETn (iRESETn),
    .iCE     (iCE),
    .iMODE   (iMODE),
    .iCTL    (iCTL),
    .iDATA   (iDATA),
    .iAUX    (iAUX),
    .oDATA   (oDATA),
    .oVALID  (oVALID)
`ifdef TMDS_DISP_MON_EN
    ,
    .oDISP   (oDISP),
    .oDISP_ERR (oDISP_ERR)
`endif
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] C0 = 10'b1101010100;
  logic [9:0] ref_ctl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] ref_terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Reference model: one pending sampled input and the symbols it will produce
  int               ref_cnt [CH];
  logic [1:0]       p_mode;
  logic [2*CH-1:0]  p_ctl;
  logic [8*CH-1:0]  p_data;
  logic [4*CH-1:0]  p_aux;
  bit               p_valid;
  logic [10*CH-1:0] exp_data;
  bit               exp_valid;

  function automatic logic [9:0] ref_video(input int ln, input logic [7:0] d);
    int n1;
    int ones;
    int bal;
    bit use_xnor;
    logic [8:0] qm;
    logic [9:0] s;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    ones = $countones(qm[7:0]);
    bal = ones - (8 - ones);
    if (ref_cnt[ln] == 0 || bal == 0) begin
      if (qm[8]) begin s = {2'b01, qm[7:0]};  ref_cnt[ln] += bal; end
      else       begin s = {2'b10, ~qm[7:0]}; ref_cnt[ln] -= bal; end
    end else if ((ref_cnt[ln] > 0 && bal > 0) || (ref_cnt[ln] < 0 && bal < 0)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      ref_cnt[ln] += (qm[8] ? 2 : 0) - bal;
    end else begin
      s = {1'b0, qm};
      ref_cnt[ln] += bal - (qm[8] ? 0 : 2);
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int ln = 0; ln < CH; ln++) ref_cnt[ln] = 0;
    p_mode = 2'd0; p_ctl = '0; p_data = '0; p_aux = '0; p_valid = 0;
    exp_data = {CH{C0}};
    exp_valid = 0;
  endtask

  task automatic model_edge();
    logic [9:0] s;
    if (!iCE) return;
    for (int ln = 0; ln < CH; ln++) begin
      case (p_mode)
        2'd0: begin s = ref_ctl[p_ctl[2*ln +: 2]]; ref_cnt[ln] = 0; end
        2'd1: s = ref_video(ln, p_data[8*ln +: 8]);
        2'd2: begin s = ref_terc4[p_aux[4*ln +: 4]]; ref_cnt[ln] = 0; end
        default: begin s = (ln % 2 == 1) ? 10'b0100110011 : 10'b1011001100; ref_cnt[ln] = 0; end
      endcase
      exp_data[10*ln +: 10] = s;
    end
    exp_valid = p_valid;
    p_mode = iMODE; p_ctl = iCTL; p_data = iDATA; p_aux = iAUX; p_valid = 1;
  endtask

  task automatic tick();
    @(posedge iCLK);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [10*CH-1:0] got_d, input logic [10*CH-1:0] req_d,
                       input logic got_v, input logic req_v);
    checks++;
    if (got_d !== req_d || got_v !== req_v) begin
      errors++;
      $display("FAIL %s: oDATA=%h oVALID=%b, required oDATA=%h oVALID=%b", name, got_d, got_v, req_d, req_v);
    end
  endtask

  task automatic check_model(input string name);
`ifdef TMDS_DISP_MON_EN
    logic [5*CH-1:0] exp_disp;
`endif
    check(name, oDATA, exp_data, oVALID, exp_valid);
`ifdef TMDS_DISP_MON_EN
    for (int ln = 0; ln < CH; ln++) exp_disp[5*ln +: 5] = 5'(ref_cnt[ln]);
    checks++;
    if (oDISP !== exp_disp || oDISP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s_disp: oDISP=%h ERR=%b, required oDISP=%h ERR=0", name, oDISP, oDISP_ERR, exp_disp);
    end
`endif
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [2*CH-1:0]  ctl;
    logic [8*CH-1:0]  data;
    logic [4*CH-1:0]  aux;
    logic [10*CH-1:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [1:0] m, input logic [2*CH-1:0] c, input logic [8*CH-1:0] d,
                              input logic [4*CH-1:0] a, input logic [10*CH-1:0] e);
    vec_t v;
    v.mode = m; v.ctl = c; v.data = d; v.aux = a; v.exp = e;
    return v;
  endfunction

  task automatic drive_random_video(input bit rand_ce);
    iCE   = rand_ce ? ($urandom_range(0, 7) != 0) : 1'b1;
    iMODE = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
    iCTL  = (2*CH)'($urandom);
    iDATA = (8*CH)'($urandom);
    iAUX  = (4*CH)'($urandom);
  endtask

  initial begin
    // lanes listed {lane2, lane1, lane0}
    vt[0]  = mk(2'd0, '0, '0, '0, {CH{C0}});
    vt[1]  = mk(2'd0, {2'd3, 2'd2, 2'd1}, '0, '0, {10'b1010101011, 10'b0101010100, 10'b0010101011});
    vt[2]  = mk(2'd1, '0, {CH{8'h00}}, '0, {CH{10'b0100000000}});
    vt[3]  = mk(2'd1, '0, {CH{8'h00}}, '0, {CH{10'b1111111111}});
    vt[4]  = mk(2'd2, '0, '0, {4'h8, 4'hF, 4'h0}, {10'b1011001100, 10'b1011000011, 10'b1010011100});
    vt[5]  = mk(2'd2, '0, '0, {4'hA, 4'h5, 4'hF}, {10'b0110011100, 10'b0100011110, 10'b1011000011});
    vt[6]  = mk(2'd3, '0, '0, '0, {10'b1011001100, 10'b0100110011, 10'b1011001100});
    vt[7]  = mk(2'd1, '0, {CH{8'h00}}, '0, {CH{10'b0100000000}});
    vt[8]  = mk(2'd1, '0, {CH{8'hFF}}, '0, {CH{10'b0011111111}});
    vt[9]  = mk(2'd1, '0, {CH{8'hFF}}, '0, {CH{10'b0011111111}});
    vt[10] = mk(2'd1, '0, {CH{8'hFF}}, '0, {CH{10'b1000000000}});

    iRESETn = 1'b0; iCE = 1'b0; iMODE = 2'd0; iCTL = '0; iDATA = '0; iAUX = '0;
    model_reset();
    #12;
    check("reset", oDATA, {CH{C0}}, oVALID, 1'b0);
    iRESETn = 1'b1;

    // iCE low right after release: nothing advances
    tick();
    check("hold_after_reset", oDATA, {CH{C0}}, oVALID, 1'b0);

    // Directed table, output checked two enabled edges after each vector is applied
    iCE = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        iMODE = vt[i].mode; iCTL = vt[i].ctl; iDATA = vt[i].data; iAUX = vt[i].aux;
      end else begin
        iMODE = 2'd0; iCTL = '0;
      end
      tick();
      if (i == 0) check("fill", oDATA, {CH{C0}}, oVALID, 1'b0);
      else        check($sformatf("vec%0d", i - 1), oDATA, vt[i-1].exp, oVALID, 1'b1);
    end

    // iCE toggling every cycle on a video stream, including mode switch on iCE rise
    for (int i = 0; i < 40; i++) begin
      iCE   = (i % 2 == 1);
      iMODE = (i < 3) ? 2'd0 : 2'd1;
      iDATA = (8*CH)'($urandom);
      tick();
      check_model("ce_toggle");
    end

    // Long randomized run with random iCE and occasional non-video modes
    for (int i = 0; i < 10000; i++) begin
      drive_random_video(1'b1);
      tick();
      check_model("random");
      if (i == 5000) begin
        iRESETn = 1'b0;
        #1;
        check("async_reset", oDATA, {CH{C0}}, oVALID, 1'b0);
        model_reset();
        @(negedge iCLK);
        iRESETn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_mc.md
Name: tmds_encoder_mc

Overview:
Parametrised multi-channel TMDS/TERC4 encoder. It is the next generation of the single-channel DVI encoder.
- Encodes CHANNELS lanes in lock-step.
- Per-cycle mode select: control period, video data, data-island TERC4, or guard band.
- Pipeline is clock-enabled.
- Sits between the video/packet timing generator and the serialisers of the HDMI transmitter.

Parameters:
- CHANNELS, 3: number of TMDS lanes encoded in parallel (1..4).
- GB_ODD_CODE, 10'b0100110011: guard-band symbol for odd-indexed lanes.
- GB_EVEN_CODE, 10'b1011001100: guard-band symbol for even-indexed lanes.

Ports:
- iCLK  in  1  pixel clock
- iRESETn  in  1  asynchronous active-low reset
- iCE  in  1  clock enable; pipeline advances only when high
- iMODE  in  2  0=control, 1=video, 2=TERC4, 3=guard band; common to all lanes
- iCTL  in  2*CHANNELS  per-lane control bits {C1,C0}; lane n = [2n+1:2n]
- iDATA  in  8*CHANNELS  per-lane video byte; lane n = [8n+7:8n]
- iAUX  in  4*CHANNELS  per-lane TERC4 nibble; lane n = [4n+3:4n]
- oDATA  out  10*CHANNELS  per-lane encoded symbol, bit 0 transmitted first
- oVALID  out  1  high when oDATA carries a symbol produced from a sampled input

Behaviour:
- Reset (iRESETn low, asynchronous):
  - All pipeline registers cleared.
  - oDATA = control symbol for CTL=0 (10'b1101010100) on every lane.
  - oVALID=0; all running disparities = 0.
- Latency: fixed 2 enabled cycles for every mode. Mode is pipelined with the data, so mode switches stay symbol-aligned.
- Stage 1, per lane (video path):
  - Count N1 of iDATA.
  - Select XNOR chaining if N1>4 or (N1==4 and iDATA[0]==0), else XOR chaining.
  - Form q_m[8:0] (q_m[8]=1 for XOR) and register it.
  - Register N1(q_m[7:0]) and N0 = 8-N1 as 4-bit values.
  - Mode, CTL and AUX are registered alongside.
- Stage 2, per lane (mode decode):
  - Mode 0: CTL 0/1/2/3 -> 1101010100 / 0010101011 / 0101010100 / 1010101011.
  - Mode 2: TERC4 lookup of the registered nibble (16-entry table, HDMI 1.4 TERC4).
  - Mode 3: even lane index -> GB_EVEN_CODE, odd -> GB_ODD_CODE.
  - Modes 0, 2 and 3 force the lane disparity to 0.
- Mode 1 (video), DVI 1.0 disparity algorithm. Disparity is a signed 5-bit register per lane.
  - Cnt==0 or N1==N0:
    - q_m[8]=1: out={01,q_m[7:0]}, Cnt+=N1-N0.
    - Else: out={10,~q_m[7:0]}, Cnt+=N0-N1.
  - (Cnt>0 and N1>N0) or (Cnt<0 and N1<N0): out={1,q_m[8],~q_m[7:0]}, Cnt+=2*q_m[8]+N0-N1.
  - Otherwise: out={0,q_m}, Cnt+=N1-N0-2*(~q_m[8]).
- Arithmetic: all disparity arithmetic is 5-bit two's complement. The value is bounded to [-10,+10] by the algorithm, so wrap never occurs.
- iCE low:
  - All registers hold, including disparity, oDATA and oVALID.
  - The output symbol repeats and no state is corrupted.
- oVALID: set after the second enabled cycle following reset release, then remains 1.
- Simultaneous events: a mode change to video in the same cycle as iCE rising behaves identically to a continuous stream.
- Reset asserted mid-stream: outputs return to reset values immediately. Disparity restarts at 0 after release.
- Lanes are fully independent except for the shared iMODE/iCE.

Optional Feature:
- Macro: TMDS_DISP_MON_EN.
- Defined:
  - Adds output oDISP (5*CHANNELS), each lane's current registered disparity.
  - Adds output oDISP_ERR (1), sticky, set if any lane disparity leaves [-10,+10]; cleared only by reset.
- Undefined: neither port exists and no monitor logic is generated.

Decomposition:
- Package tmds_pkg:
  - Mode enum (TMDS_CTL, TMDS_VID, TMDS_TERC4, TMDS_GB).
  - Four control-code constants.
  - 16-entry TERC4 constant array.
  - Disparity bound constant (10).
- Sub-module tmds_lane_enc: one lane's two pipeline stages and disparity register. The top generates CHANNELS instances and the shared oVALID logic.

Test Plan:
1. Reset, mode 0, CTL=0 on all lanes -> every lane 1101010100; oVALID=0 until 2 enabled cycles after release.
2. Mode 1, lane 0 data 0x00 twice from Cnt=0 -> 0100000000 (Cnt=-8), then 1111111111 (Cnt=+2).
3. Mode 2, AUX=0x0 then 0xF -> 1010011100 then 1011000011 two cycles later; disparity reads 0 (with TMDS_DISP_MON_EN).
4. Mode 3, CHANNELS=3 -> lanes 0/1/2 output 1011001100 / 0100110011 / 1011001100.
5. Video stream with iCE toggled 0/1 every cycle -> output sequence equals the same stream with iCE=1, each symbol held during iCE=0.
6. 10k random video bytes, all lanes, with a reference-model compare -> bit-exact match; oDISP_ERR stays 0.
